ame_equation_builder: RTL and testbench

Builds the affine motion-estimation normal-equation system from a stream of per-pixel gradient samples and hands it to the equation solver. Each sample produces a coefficient vector c and a residual d. The block accumulates A[i][j] += c_i*c_j and B[i] += c_i*d over one block. It then presents the 6x7 matrix in solver packing, where row i holds A[i][0..5] in columns 0..5 and B[i] in column 6, and pulses the solver start.

---
 rtl/ame_equation_builder.sv | 238 +++++++++++++++++++++++
 tb/tb_ame_equation_builder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ame_equation_builder.sv
// Affine motion-estimation normal-equation builder.
// Accumulates the upper triangle of A = sum(c*c') and B = sum(c*d) from a
// stream of gradient samples, then presents the 6x7 system to the solver
// (column 6 carries B) together with a one-cycle start pulse.
module ame_equation_builder #(
   parameter int COMP_DATA_BITS = 64,
   parameter int GRAD_BITS      = 16,
   parameter int POS_BITS       = 8,
   parameter int DIFF_BITS      = 16
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic                                     comp_init_i,
   input  logic                                     affine_param6_i,
   input  logic                                     samp_valid_i,
   output logic                                     samp_ready_o,
   input  logic                                     samp_last_i,
   input  logic [GRAD_BITS-1:0]                     samp_gx_i,
   input  logic [GRAD_BITS-1:0]                     samp_gy_i,
   input  logic [POS_BITS-1:0]                      samp_x_i,
   input  logic [POS_BITS-1:0]                      samp_y_i,
   input  logic [DIFF_BITS-1:0]                     samp_d_i,
   output logic                                     busy_o,
   output logic                                     comp_init_o,
   output logic                                     affine_param6_o,
   output logic [5:0][6:0][COMP_DATA_BITS-1:0]      comp_data_o
);

   // Coefficient width: position*gradient plus one bit for the 4-param sum
   // and one bit of headroom for the zero-extended coordinate.
   localparam int CW = GRAD_BITS + POS_BITS + 2;
   localparam int W  = COMP_DATA_BITS;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        drain_cnt_q, drain_cnt_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              init_out_q, init_out_d;
   logic              model_q, model_d;
   logic              accept;

   logic              v1_q, v1_d;
   logic              v2_q, v2_d;
   logic signed [CW-1:0]        coef_q [6];
   logic signed [CW-1:0]        coef_d [6];
   logic signed [DIFF_BITS-1:0] diff_q, diff_d;

   logic signed [W-1:0] prod_a_q [6][6];
   logic signed [W-1:0] prod_a_d [6][6];
   logic signed [W-1:0] prod_b_q [6];
   logic signed [W-1:0] prod_b_d [6];

   logic [W-1:0] acc_a_q [6][6];
   logic [W-1:0] acc_a_d [6][6];
   logic [W-1:0] acc_b_q [6];
   logic [W-1:0] acc_b_d [6];

   logic signed [CW-1:0] gx_e, gy_e, x_e, y_e;
   logic signed [CW-1:0] xgx, xgy, ygx, ygy;

   // A sample colliding with a frame restart is dropped.
   assign accept = samp_valid_i & ready_q & ~comp_init_i;

   // Next-state and registered-output values for the frame sequencer.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         ACCUM: begin
            if (accept && samp_last_i) begin
               state_d     = DRAIN;
               drain_cnt_d = 2'd0;
            end
         end
         DRAIN: begin
            if (drain_cnt_q == 2'd2) begin
               state_d = DONE;
            end else begin
               drain_cnt_d = drain_cnt_q + 2'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (comp_init_i) begin
         state_d     = ACCUM;
         drain_cnt_d = 2'd0;
      end
      ready_d    = (state_d == ACCUM);
      busy_d     = (state_d != IDLE);
      init_out_d = (state_q == DONE) && !comp_init_i;
      model_d    = comp_init_i ? affine_param6_i : model_q;
   end

   // Frame sequencer state and its registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         drain_cnt_q <= 2'd0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         init_out_q  <= 1'b0;
         model_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         init_out_q  <= init_out_d;
         model_q     <= model_d;
      end
   end

   // Stage 1: build the coefficient vector for the model latched at frame start.
   always_comb begin
      gx_e = CW'(signed'(samp_gx_i));
      gy_e = CW'(signed'(samp_gy_i));
      x_e  = CW'(samp_x_i);
      y_e  = CW'(samp_y_i);
      xgx  = x_e * gx_e;
      xgy  = x_e * gy_e;
      ygx  = y_e * gx_e;
      ygy  = y_e * gy_e;
      if (model_q) begin
         coef_d[0] = gx_e;
         coef_d[1] = gy_e;
         coef_d[2] = xgx;
         coef_d[3] = xgy;
         coef_d[4] = ygx;
         coef_d[5] = ygy;
      end else begin
         coef_d[0] = '0;
         coef_d[1] = '0;
         coef_d[2] = gx_e;
         coef_d[3] = gy_e;
         coef_d[4] = xgx + ygy;
         coef_d[5] = ygx - xgy;
      end
      diff_d = signed'(samp_d_i);
      v1_d   = accept;
   end

   // Stage 2: upper-triangle products c_i*c_j and right-hand products c_i*d.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 6; j++) begin
            if (j >= i) begin
               prod_a_d[i][j] = W'(coef_q[i]) * W'(coef_q[j]);
            end else begin
               prod_a_d[i][j] = '0;
            end
         end
         prod_b_d[i] = W'(coef_q[i]) * W'(diff_q);
      end
      v2_d = v1_q & ~comp_init_i;
   end

   // Stage 3: wrap-around accumulation, cleared whenever a frame (re)starts.
   always_comb begin
      acc_a_d = acc_a_q;
      acc_b_d = acc_b_q;
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 6; j++) begin
            if (comp_init_i) begin
               acc_a_d[i][j] = '0;
            end else if (v2_q && (j >= i)) begin
               acc_a_d[i][j] = acc_a_q[i][j] + prod_a_q[i][j];
            end
         end
         if (comp_init_i) begin
            acc_b_d[i] = '0;
         end else if (v2_q) begin
            acc_b_d[i] = acc_b_q[i] + prod_b_q[i];
         end
      end
   end

   // Datapath pipeline registers and accumulators.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         diff_q <= '0;
         for (int i = 0; i < 6; i++) begin
            coef_q[i]   <= '0;
            prod_b_q[i] <= '0;
            acc_b_q[i]  <= '0;
            for (int j = 0; j < 6; j++) begin
               prod_a_q[i][j] <= '0;
               acc_a_q[i][j]  <= '0;
            end
         end
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         diff_q <= diff_d;
         for (int i = 0; i < 6; i++) begin
            coef_q[i]   <= coef_d[i];
            prod_b_q[i] <= prod_b_d[i];
            acc_b_q[i]  <= acc_b_d[i];
            for (int j = 0; j < 6; j++) begin
               prod_a_q[i][j] <= prod_a_d[i][j];
               acc_a_q[i][j]  <= acc_a_d[i][j];
            end
         end
      end
   end

   // Solver packing: lower triangle mirrors the accumulated upper triangle.
   always_comb begin
      comp_data_o = '0;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 6; c++) begin
            if (r <= c) begin
               comp_data_o[r][c] = acc_a_q[r][c];
            end else begin
               comp_data_o[r][c] = acc_a_q[c][r];
            end
         end
         comp_data_o[r][6] = acc_b_q[r];
      end
   end

   assign samp_ready_o    = ready_q;
   assign busy_o          = busy_q;
   assign comp_init_o     = init_out_q;
   assign affine_param6_o = model_q;

endmodule

// File: tb/tb_ame_equation_builder.sv
// Directed testbench for ame_equation_builder with hand-computed expectations.
module tb_ame_equation_builder;

   localparam int W = 64;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic                  comp_init_i;
   logic                  affine_param6_i;
   logic                  samp_valid_i;
   logic                  samp_ready_o;
   logic                  samp_last_i;
   logic [15:0]           samp_gx_i;
   logic [15:0]           samp_gy_i;
   logic [7:0]            samp_x_i;
   logic [7:0]            samp_y_i;
   logic [15:0]           samp_d_i;
   logic                  busy_o;
   logic                  comp_init_o;
   logic                  affine_param6_o;
   logic [5:0][6:0][W-1:0] comp_data_o;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int p0       = 0;

   ame_equation_builder dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .comp_init_i     (comp_init_i),
      .affine_param6_i (affine_param6_i),
      .samp_valid_i    (samp_valid_i),
      .samp_ready_o    (samp_ready_o),
      .samp_last_i     (samp_last_i),
      .samp_gx_i       (samp_gx_i),
      .samp_gy_i       (samp_gy_i),
      .samp_x_i        (samp_x_i),
      .samp_y_i        (samp_y_i),
      .samp_d_i        (samp_d_i),
      .busy_o          (busy_o),
      .comp_init_o     (comp_init_o),
      .affine_param6_o (affine_param6_o),
      .comp_data_o     (comp_data_o)
   );

   // Free-running clock.
   always #5 clk_i = ~clk_i;

   // Count solver start pulses away from the active edge.
   always @(negedge clk_i) begin
      if (comp_init_o) pulses++;
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input int gx, input int gy,
                                input int x, input int y, input int d,
                                input logic last);
      samp_valid_i = v;
      samp_gx_i    = 16'(gx);
      samp_gy_i    = 16'(gy);
      samp_x_i     = 8'(x);
      samp_y_i     = 8'(y);
      samp_d_i     = 16'(d);
      samp_last_i  = last;
   endtask

   task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                              input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic checkFlag(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic startFrame(input logic mode);
      comp_init_i     = 1'b1;
      affine_param6_i = mode;
      step();
      comp_init_i     = 1'b0;
   endtask

   task automatic sendSample(input int gx, input int gy, input int x,
                             input int y, input int d, input logic last);
      applyStimulus(1'b1, gx, gy, x, y, d, last);
      step();
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
   endtask

   task automatic waitPulse(input string tag, input int budget);
      int n = 0;
      while (!comp_init_o && n < budget) begin
         step();
         n++;
      end
      checkFlag({tag, " pulse"}, comp_init_o, 1'b1);
   endtask

   initial begin
      rst_i           = 1'b1;
      comp_init_i     = 1'b0;
      affine_param6_i = 1'b0;
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
      step();
      step();
      checkFlag("rst ready", samp_ready_o, 1'b0);
      checkFlag("rst busy", busy_o, 1'b0);
      checkFlag("rst init", comp_init_o, 1'b0);
      checkFlag("rst param6", affine_param6_o, 1'b0);
      checkFlag("rst data", |comp_data_o, 1'b0);
      rst_i = 1'b0;
      step();

      $display("[TB] 6-param single sample, latency");
      startFrame(1'b1);
      checkFlag("accum ready", samp_ready_o, 1'b1);
      checkFlag("accum busy", busy_o, 1'b1);
      checkFlag("accum param6", affine_param6_o, 1'b1);
      p0 = pulses;
      sendSample(2, 3, 1, 1, 4, 1'b1);
      checkFlag("drain ready", samp_ready_o, 1'b0);
      step();
      step();
      step();
      checkFlag("t4 init", comp_init_o, 1'b0);
      checkFlag("t4 busy", busy_o, 1'b1);
      step();
      checkFlag("t5 init", comp_init_o, 1'b1);
      checkFlag("t5 busy", busy_o, 1'b0);
      checkOutput("s1 A00", comp_data_o[0][0], 64'd4);
      checkOutput("s1 A01", comp_data_o[0][1], 64'd6);
      checkOutput("s1 A10", comp_data_o[1][0], 64'd6);
      checkOutput("s1 A11", comp_data_o[1][1], 64'd9);
      checkOutput("s1 A55", comp_data_o[5][5], 64'd9);
      checkOutput("s1 A25", comp_data_o[2][5], 64'd6);
      checkOutput("s1 B0", comp_data_o[0][6], 64'd8);
      checkOutput("s1 B1", comp_data_o[1][6], 64'd12);
      checkOutput("s1 B5", comp_data_o[5][6], 64'd12);
      step();
      checkFlag("t6 init", comp_init_o, 1'b0);
      step();
      checkOutput("s1 hold A00", comp_data_o[0][0], 64'd4);
      checkOutput("s1 pulses", 64'(pulses - p0), 64'd1);

      $display("[TB] 4-param single sample");
      startFrame(1'b0);
      checkOutput("s2 cleared A00", comp_data_o[0][0], 64'd0);
      checkFlag("s2 param6", affine_param6_o, 1'b0);
      sendSample(2, 3, 1, 1, 4, 1'b1);
      waitPulse("s2", 10);
      checkOutput("s2 A22", comp_data_o[2][2], 64'd4);
      checkOutput("s2 A23", comp_data_o[2][3], 64'd6);
      checkOutput("s2 A24", comp_data_o[2][4], 64'd10);
      checkOutput("s2 A44", comp_data_o[4][4], 64'd25);
      checkOutput("s2 A45", comp_data_o[4][5], -64'sd5);
      checkOutput("s2 A54", comp_data_o[5][4], -64'sd5);
      checkOutput("s2 A55", comp_data_o[5][5], 64'd1);
      checkOutput("s2 B4", comp_data_o[4][6], 64'd20);
      checkOutput("s2 B5", comp_data_o[5][6], -64'sd4);
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 7; c++) begin
            if (r < 2 || c < 2) begin
               checkOutput($sformatf("s2 zero r%0d c%0d", r, c), comp_data_o[r][c], 64'd0);
            end
         end
      end

      $display("[TB] 64 back-to-back samples");
      startFrame(1'b1);
      p0 = pulses;
      for (int i = 0; i < 64; i++) begin
         applyStimulus(1'b1, 1, 0, 2, 3, -1, (i == 63));
         step();
      end
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
      waitPulse("s3", 10);
      checkOutput("s3 A00", comp_data_o[0][0], 64'd64);
      checkOutput("s3 A22", comp_data_o[2][2], 64'd256);
      checkOutput("s3 A44", comp_data_o[4][4], 64'd576);
      checkOutput("s3 A24", comp_data_o[2][4], 64'd384);
      checkOutput("s3 A42", comp_data_o[4][2], 64'd384);
      checkOutput("s3 B0", comp_data_o[0][6], -64'sd64);
      checkOutput("s3 B2", comp_data_o[2][6], -64'sd128);
      checkOutput("s3 B4", comp_data_o[4][6], -64'sd192);
      step();
      step();
      step();
      checkOutput("s3 pulses", 64'(pulses - p0), 64'd1);

      $display("[TB] gapped valid, samples offered outside ACCUM");
      applyStimulus(1'b1, 100, 100, 5, 5, 9, 1'b1);
      step();
      step();
      startFrame(1'b1);
      for (int k = 0; k < 5; k++) begin
         if (k % 2 == 0) applyStimulus(1'b1, 1, 1, 1, 0, 2, (k == 4));
         else            applyStimulus(1'b0, 100, 100, 5, 5, 9, 1'b1);
         step();
      end
      checkFlag("s4 drain ready", samp_ready_o, 1'b0);
      applyStimulus(1'b1, 100, 100, 5, 5, 9, 1'b1);
      step();
      step();
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
      waitPulse("s4", 10);
      checkOutput("s4 A00", comp_data_o[0][0], 64'd3);
      checkOutput("s4 A01", comp_data_o[0][1], 64'd3);
      checkOutput("s4 A23", comp_data_o[2][3], 64'd3);
      checkOutput("s4 A33", comp_data_o[3][3], 64'd3);
      checkOutput("s4 A44", comp_data_o[4][4], 64'd0);
      checkOutput("s4 B0", comp_data_o[0][6], 64'd6);
      checkOutput("s4 B3", comp_data_o[3][6], 64'd6);
      checkOutput("s4 B4", comp_data_o[4][6], 64'd0);

      $display("[TB] restart mid-ACCUM");
      step();
      p0 = pulses;
      startFrame(1'b1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 7, 5, 3, 2, 3, 1'b0);
         step();
      end
      comp_init_i     = 1'b1;
      affine_param6_i = 1'b1;
      applyStimulus(1'b1, 50, 0, 0, 0, 9, 1'b1);
      step();
      comp_init_i = 1'b0;
      checkFlag("s5 ready after restart", samp_ready_o, 1'b1);
      sendSample(1, 0, 0, 0, 1, 1'b1);
      waitPulse("s5", 10);
      checkOutput("s5 A00", comp_data_o[0][0], 64'd1);
      checkOutput("s5 B0", comp_data_o[0][6], 64'd1);
      checkOutput("s5 A01", comp_data_o[0][1], 64'd0);
      checkOutput("s5 A11", comp_data_o[1][1], 64'd0);
      checkOutput("s5 A22", comp_data_o[2][2], 64'd0);
      step();
      step();
      step();
      checkOutput("s5 pulses", 64'(pulses - p0), 64'd1);

      $display("[TB] reset during DRAIN");
      startFrame(1'b1);
      sendSample(2, 3, 1, 1, 4, 1'b1);
      p0 = pulses;
      step();
      rst_i = 1'b1;
      #1;
      checkFlag("s6 rst ready", samp_ready_o, 1'b0);
      checkFlag("s6 rst busy", busy_o, 1'b0);
      checkFlag("s6 rst init", comp_init_o, 1'b0);
      checkFlag("s6 rst param6", affine_param6_o, 1'b0);
      checkFlag("s6 rst data", |comp_data_o, 1'b0);
      step();
      step();
      rst_i = 1'b0;
      for (int i = 0; i < 6; i++) step();
      checkOutput("s6 no pulse", 64'(pulses - p0), 64'd0);
      startFrame(1'b1);
      sendSample(2, 3, 1, 1, 4, 1'b1);
      waitPulse("s6 new frame", 10);
      checkOutput("s6 A00", comp_data_o[0][0], 64'd4);
      checkOutput("s6 B1", comp_data_o[1][6], 64'd12);
      checkFlag("s6 param6", affine_param6_o, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
